hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It drives the control inputs of the IF/ID register (`if_id_flush`, `if_id_stall`, `mop_stall`) and the PC hold and ID/EX bubble signals. It resolves four hazard sources: load-use interlocks, EX-stage branch redirects, multi-micro-op instruction expansion in ID, and post-serializing-instruction pipeline drain. It holds one small FSM plus a micro-op index counter and a drain counter.

## Interface
- `DRAIN_CYCLES`, default 3: number of NOP slots injected into ID after a serializing instruction leaves ID. Legal range 1..7.
- `MOP_W`, default 3: width of the micro-op length and index fields.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_rs1`, `id_rs2`  in  5 each  source register indices of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the source operand is actually read.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `br_redirect`  in  1  EX resolved a taken or mispredicted branch this cycle.
- `id_mop_len`  in  MOP_W  micro-op count of the ID instruction. Values 0 and 1 mean an ordinary instruction.
- `id_serial`  in  1  the ID instruction is serializing (fence.i, CSR write).
- `pc_stall`  out  1  hold the PC.
- `if_id_stall`  out  1  hold the IF/ID register.
- `if_id_flush`  out  1  zero the IF/ID register.
- `mop_stall`  out  1  load a NOP (0x13) into ID and hold the PC side.
- `id_ex_flush`  out  1  insert a bubble into ID/EX.
- `mop_idx`  out  MOP_W  registered index of the micro-op the ID expander emits this cycle.
- `busy`  out  1  FSM not in S_RUN.

## Operation
- `load_use` (combinational) = `ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- Per-cycle priority: `rst` > `br_redirect` > S_DRAIN action > `load_use` > micro-op sequencing / serialize start.
- While `rst` is high:
  - all outputs are 0.
  - next state is S_RUN, `mop_idx` = 0, drain counter = 0.
- `br_redirect`, in S_RUN or S_MOP:
  - `if_id_flush` = 1, `id_ex_flush` = 1; all other stall outputs 0.
  - Next state S_RUN, `mop_idx` cleared (aborts a wrong-path expansion).
- `br_redirect` in S_DRAIN: flush outputs are asserted as above, and the drain continues with its counter unchanged in behaviour.
- Load-use, in S_RUN or S_MOP:
  - `pc_stall` = 1, `if_id_stall` = 1, `id_ex_flush` = 1 for exactly the cycle the condition holds.
  - `mop_idx` and state are unchanged.
- S_RUN, `id_mop_len` >= 2, no hazard:
  - `pc_stall` = `if_id_stall` = 1.
  - Micro-op 0 issues this cycle; `mop_idx` <= 1; go to S_MOP.
- S_MOP, no hazard:
  - If `mop_idx == id_mop_len - 1`: stalls drop, `mop_idx` <= 0, go to S_RUN (or to S_DRAIN if `id_serial`).
  - Otherwise: `pc_stall` = `if_id_stall` = 1, `mop_idx` increments.
- Serialize start: in S_RUN with `id_serial`, `id_mop_len` <= 1 and no hazard:
  - the instruction advances to EX normally.
  - drain counter <= DRAIN_CYCLES; go to S_DRAIN.
- S_DRAIN: `mop_stall` = `pc_stall` = 1; counter decrements; go to S_RUN on the cycle the counter equals 1.
- Invariants:
  - `if_id_stall` and `mop_stall` are never both 1.
  - `mop_idx` is 0 in S_RUN and S_DRAIN.

## Timing
- All outputs except `mop_idx` and `busy` are combinational from state and inputs: zero-cycle response.
- A micro-op instruction of length N occupies ID for exactly N cycles, with `mop_idx` = 0..N-1; add 1 cycle per intervening load-use stall.
- Serialize drain: exactly DRAIN_CYCLES NOPs enter ID, starting the cycle after the serializing instruction leaves ID.
- Reset asserted mid-S_MOP or mid-S_DRAIN returns to S_RUN on the next edge, with no residual stall.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_rs1_used`=1 -> `pc_stall`/`if_id_stall`/`id_ex_flush` = 1 for 1 cycle. With `ex_rd`=0 -> no stall.
- **Micro-op expansion:** `id_mop_len`=4 -> `mop_idx` reads 0,1,2,3 over 4 cycles, `if_id_stall`=1 for the first 3 cycles, then `busy`=0.
- **Redirect abort:** `br_redirect` at `mop_idx`=2 of length 5 -> `if_id_flush`=`id_ex_flush`=1, next cycle state S_RUN, `mop_idx`=0.
- **Serialize drain:** `id_serial`=1, DRAIN_CYCLES=3 -> exactly 3 cycles of `mop_stall`=`pc_stall`=1, then normal fetch.
- **Simultaneous events:** load-use and `id_mop_len`=3 in the same cycle -> 1 bubble first, then 3-cycle sequence. Load-use and `br_redirect` together -> flush only, no stall.
- **Reset mid-sequence:** `rst` at `mop_idx`=1 -> all outputs 0 while asserted; after release S_RUN, `mop_idx`=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline control outputs exchanged
// between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int MOP_W = 3
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             br_redirect;
    logic [MOP_W-1:0] id_mop_len;
    logic             id_serial;

    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             mop_stall;
    logic             id_ex_flush;
    logic [MOP_W-1:0] mop_idx;
    logic             busy;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_read, ex_rd,
               br_redirect, id_mop_len, id_serial,
        input  pc_stall, if_id_stall, if_id_flush, mop_stall, id_ex_flush,
               mop_idx, busy
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_read, ex_rd,
               br_redirect, id_mop_len, id_serial,
        output pc_stall, if_id_stall, if_id_flush, mop_stall, id_ex_flush,
               mop_idx, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core: load-use interlock,
// branch redirect flush, micro-op expansion in ID and post-serialize drain.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MOP_W        = 3
) (
    input  logic           clk,
    input  logic           rst,
    hazard_ctrl_if.slave   hz
);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MOP   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [MOP_W-1:0] mop_idx_q, mop_idx_d;
    logic [CNT_W-1:0] drain_q, drain_d;

    logic             load_use;
    logic [MOP_W:0]   idx_plus1;
    logic             mop_last;
    logic             pc_stall_c, if_id_stall_c, if_id_flush_c, mop_stall_c, id_ex_flush_c;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

    // Extended compare avoids underflow of id_mop_len-1 and ends a sequence
    // whose length shrank underneath it instead of running away.
    assign idx_plus1 = {1'b0, mop_idx_q} + {{MOP_W{1'b0}}, 1'b1};
    assign mop_last  = idx_plus1 >= {1'b0, hz.id_mop_len};

    always_comb begin
        state_d       = state_q;
        mop_idx_d     = mop_idx_q;
        drain_d       = drain_q;
        pc_stall_c    = 1'b0;
        if_id_stall_c = 1'b0;
        if_id_flush_c = 1'b0;
        mop_stall_c   = 1'b0;
        id_ex_flush_c = 1'b0;

        if (rst) begin
            state_d   = S_RUN;
            mop_idx_d = '0;
            drain_d   = '0;
        end else if (hz.br_redirect) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            if (state_q == S_DRAIN) begin
                drain_d = drain_q - 1'b1;
                if (drain_q <= 1) state_d = S_RUN;
            end else begin
                state_d   = S_RUN;
                mop_idx_d = '0;
            end
        end else if (state_q == S_DRAIN) begin
            mop_stall_c = 1'b1;
            pc_stall_c  = 1'b1;
            drain_d     = drain_q - 1'b1;
            if (drain_q <= 1) state_d = S_RUN;
        end else if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else if (state_q == S_RUN) begin
            if (hz.id_mop_len >= 2) begin
                pc_stall_c    = 1'b1;
                if_id_stall_c = 1'b1;
                mop_idx_d     = 1;
                state_d       = S_MOP;
            end else if (hz.id_serial) begin
                drain_d = CNT_W'(DRAIN_CYCLES);
                state_d = S_DRAIN;
            end
        end else begin
            if (mop_last) begin
                mop_idx_d = '0;
                if (hz.id_serial) begin
                    drain_d = CNT_W'(DRAIN_CYCLES);
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end else begin
                pc_stall_c    = 1'b1;
                if_id_stall_c = 1'b1;
                mop_idx_d     = mop_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            mop_idx_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            mop_idx_q <= mop_idx_d;
            drain_q   <= drain_d;
        end
    end

    assign hz.pc_stall    = pc_stall_c;
    assign hz.if_id_stall = if_id_stall_c;
    assign hz.if_id_flush = if_id_flush_c;
    assign hz.mop_stall   = mop_stall_c;
    assign hz.id_ex_flush = id_ex_flush_c;
    // Registered outputs are masked so reset silences everything immediately.
    assign hz.mop_idx     = rst ? '0 : mop_idx_q;
    assign hz.busy        = !rst && (state_q != S_RUN);
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of single-cycle vectors from S_RUN plus
// hand-written multi-cycle sequences with hand-computed expectations.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.MOP_W(3)) hz ();

    hazard_ctrl #(.DRAIN_CYCLES(3), .MOP_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic [4:0] exp_o; // {pc_stall, if_id_stall, if_id_flush, mop_stall, id_ex_flush}
    } vec_t;

    vec_t vecs [10];

    // Packed view: {pc_stall, if_id_stall, if_id_flush, mop_stall, id_ex_flush, busy, mop_idx}
    function automatic logic [8:0] pack_out();
        return {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.mop_stall,
                hz.id_ex_flush, hz.busy, hz.mop_idx};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got pc/ifs/iff/mop/idex/busy/idx=%b required %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic br, input logic [2:0] len, input logic ser);
        hz.ex_mem_read = mr;
        hz.ex_rd       = rd;
        hz.id_rs1      = rs1;
        hz.id_rs2      = rs2;
        hz.id_rs1_used = u1;
        hz.id_rs2_used = u2;
        hz.br_redirect = br;
        hz.id_mop_len  = len;
        hz.id_serial   = ser;
    endtask

    // One cycle: advance to the falling edge, drive, settle, compare.
    task automatic cyc(input string name, input logic mr, input logic br,
                       input logic [2:0] len, input logic ser, input logic [8:0] exp);
        @(negedge clk);
        set_in(mr, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, br, len, ser);
        #1;
        check(name, pack_out(), exp);
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'b00000};
        vecs[1] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 5'b11001};
        vecs[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'b00000};
        vecs[3] = '{1'b1, 5'd9,  5'd1,  5'd9,  1'b0, 1'b1, 1'b0, 5'b11001};
        vecs[4] = '{1'b1, 5'd7,  5'd7,  5'd7,  1'b0, 1'b0, 1'b0, 5'b00000};
        vecs[5] = '{1'b0, 5'd3,  5'd3,  5'd3,  1'b1, 1'b1, 1'b0, 5'b00000};
        vecs[6] = '{1'b1, 5'd4,  5'd6,  5'd8,  1'b1, 1'b1, 1'b0, 5'b00000};
        vecs[7] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'b00101};
        vecs[8] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'b00101};
        vecs[9] = '{1'b1, 5'd31, 5'd2,  5'd31, 1'b1, 1'b1, 1'b0, 5'b11001};

        rst = 1'b1;
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs_zero", pack_out(), 9'b0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        check("after_reset_idle", pack_out(), 9'b0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_in(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].u1, vecs[i].u2, vecs[i].br, 3'd0, 1'b0);
            #1;
            check($sformatf("vec%0d", i), pack_out(), {vecs[i].exp_o, 1'b0, 3'd0});
        end

        // Micro-op expansion, length 4
        cyc("mop4_c0", 1'b0, 1'b0, 3'd4, 1'b0, 9'b11000_0_000);
        cyc("mop4_c1", 1'b0, 1'b0, 3'd4, 1'b0, 9'b11000_1_001);
        cyc("mop4_c2", 1'b0, 1'b0, 3'd4, 1'b0, 9'b11000_1_010);
        cyc("mop4_c3", 1'b0, 1'b0, 3'd4, 1'b0, 9'b00000_1_011);
        cyc("mop4_done", 1'b0, 1'b0, 3'd0, 1'b0, 9'b00000_0_000);

        // Redirect aborts a length-5 expansion at mop_idx 2
        cyc("abort_c0", 1'b0, 1'b0, 3'd5, 1'b0, 9'b11000_0_000);
        cyc("abort_c1", 1'b0, 1'b0, 3'd5, 1'b0, 9'b11000_1_001);
        cyc("abort_br", 1'b0, 1'b1, 3'd5, 1'b0, 9'b00101_1_010);
        cyc("abort_after", 1'b0, 1'b0, 3'd0, 1'b0, 9'b00000_0_000);

        // Serialize drain of 3 NOP slots
        cyc("ser_issue", 1'b0, 1'b0, 3'd1, 1'b1, 9'b00000_0_000);
        cyc("drain_1", 1'b0, 1'b0, 3'd0, 1'b0, 9'b10010_1_000);
        cyc("drain_2", 1'b0, 1'b0, 3'd0, 1'b0, 9'b10010_1_000);
        cyc("drain_3", 1'b0, 1'b0, 3'd0, 1'b0, 9'b10010_1_000);
        cyc("drain_done", 1'b0, 1'b0, 3'd0, 1'b0, 9'b00000_0_000);

        // Load-use and micro-op start in the same cycle: bubble first
        cyc("lu_mop_bubble", 1'b1, 1'b0, 3'd3, 1'b0, 9'b11001_0_000);
        cyc("lu_mop_c0", 1'b0, 1'b0, 3'd3, 1'b0, 9'b11000_0_000);
        cyc("lu_mop_c1", 1'b0, 1'b0, 3'd3, 1'b0, 9'b11000_1_001);
        cyc("lu_mop_c2", 1'b0, 1'b0, 3'd3, 1'b0, 9'b00000_1_010);
        cyc("lu_mop_done", 1'b0, 1'b0, 3'd0, 1'b0, 9'b00000_0_000);

        // Load-use inside S_MOP holds mop_idx for one extra cycle
        cyc("mop_lu_c0", 1'b0, 1'b0, 3'd3, 1'b0, 9'b11000_0_000);
        cyc("mop_lu_stall", 1'b1, 1'b0, 3'd3, 1'b0, 9'b11001_1_001);
        cyc("mop_lu_c1", 1'b0, 1'b0, 3'd3, 1'b0, 9'b11000_1_001);
        cyc("mop_lu_c2", 1'b0, 1'b0, 3'd3, 1'b0, 9'b00000_1_010);
        cyc("mop_lu_done", 1'b0, 1'b0, 3'd0, 1'b0, 9'b00000_0_000);

        // Redirect during drain: flush only, drain count still advances
        cyc("dbr_issue", 1'b0, 1'b0, 3'd1, 1'b1, 9'b00000_0_000);
        cyc("dbr_drain1", 1'b0, 1'b0, 3'd0, 1'b0, 9'b10010_1_000);
        cyc("dbr_br", 1'b0, 1'b1, 3'd0, 1'b0, 9'b00101_1_000);
        cyc("dbr_drain3", 1'b0, 1'b0, 3'd0, 1'b0, 9'b10010_1_000);
        cyc("dbr_done", 1'b0, 1'b0, 3'd0, 1'b0, 9'b00000_0_000);

        // Reset asserted at mop_idx 1
        cyc("rmid_c0", 1'b0, 1'b0, 3'd4, 1'b0, 9'b11000_0_000);
        cyc("rmid_c1", 1'b0, 1'b0, 3'd4, 1'b0, 9'b11000_1_001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rmid_rst_a", pack_out(), 9'b0);
        @(negedge clk);
        hz.id_mop_len = 3'd0;
        #1;
        check("rmid_rst_b", pack_out(), 9'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmid_release", pack_out(), 9'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
